// File: rtl/jk_mod_counter_pkg.sv
// Shared JK cell command encoding and the set/reset/hold decode used for
// jump targets (wrap and parallel load).
package jk_counter_pkg;

  // Encoding is {J,K}, so a command casts straight onto the cell inputs.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_RST  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_t;

  function automatic jk_cmd_t jk_for(input logic q_i, input logic target_i);
    if (target_i && !q_i)      return JK_SET;
    else if (!target_i && q_i) return JK_RST;
    else                       return JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// Single JK flip-flop with synchronous active-low reset to INIT.
module jk_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= INIT;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK cells, with saturating parallel
// load, combinational terminal count and a sticky wrap flag.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] j_vec, k_vec;
  logic [WIDTH-1:0] load_tgt, jump_tgt;
  logic [WIDTH:0]   carry_up, carry_dn;
  logic             at_bound, wrap_evt, do_jump;

  assign at_bound = up_dn ? (q == MAX_V) : (q == '0);
  assign wrap_evt = en & at_bound;
  assign tc       = rst & ~load & wrap_evt;

  // Out-of-range load values clamp to the top of the count range.
  assign load_tgt = ({1'b0, load_val} >= MOD_W) ? MAX_V : load_val;
  assign do_jump  = load | wrap_evt;
  assign jump_tgt = load ? load_tgt : (up_dn ? '0 : MAX_V);

  // Prefix-AND chains give each bit's toggle condition for +1 / -1.
  always_comb begin
    carry_up    = '0;
    carry_dn    = '0;
    carry_up[0] = 1'b1;
    carry_dn[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry_up[i+1] = carry_up[i] & q[i];
      carry_dn[i+1] = carry_dn[i] & ~q[i];
    end
  end

  always_comb begin
    jk_cmd_t cmd;
    j_vec = '0;
    k_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cmd = JK_HOLD;
      if (do_jump)
        cmd = jk_for(q[i], jump_tgt[i]);
      else if (en && (up_dn ? carry_up[i] : carry_dn[i]))
        cmd = JK_TOG;
      {j_vec[i], k_vec[i]} = cmd;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(.INIT(RST_V[i])) u_cell (
      .clk   (clk),
      .rst   (rst),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst)          wrap <= 1'b0;
    else if (load)     wrap <= 1'b0;
    else if (wrap_evt) wrap <= 1'b1;
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed scoreboard bench: a MODULUS=10 and a MODULUS=16 counter share inputs;
// each queued entry names the instance and its expected pre-edge outputs.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, tc16, wrap10, wrap16;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(q10), .q_bar(qb10), .tc(tc10), .wrap(wrap10));

  jk_mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) u16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .q(q16), .q_bar(qb16), .tc(tc16), .wrap(wrap16));

  typedef struct {
    bit         sel16;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against queue head.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [3:0] aq, aqb;
      logic       atc, awr;
      e   = sb.pop_front();
      aq  = e.sel16 ? q16  : q10;
      aqb = e.sel16 ? qb16 : qb10;
      atc = e.sel16 ? tc16 : tc10;
      awr = e.sel16 ? wrap16 : wrap10;
      cmp(e.sel16 ? "q16"  : "q10",  aq, e.q);
      cmp(e.sel16 ? "qb16" : "qb10", aqb, ~e.q);
      cmp(e.sel16 ? "tc16" : "tc10", {3'b0, atc}, {3'b0, e.tc});
      cmp(e.sel16 ? "wr16" : "wr10", {3'b0, awr}, {3'b0, e.wrap});
    end
  end

  // Drive one cycle's inputs; expectation is the state seen before the next edge.
  task automatic step(input bit chk, input bit sel16, input bit r, input bit ld,
                      input logic [3:0] lv, input bit e, input bit u,
                      input int eq, input bit etc, input bit ew);
    exp_t x;
    @(posedge clk); #1;
    rst = r; load = ld; load_val = lv; en = e; up_dn = u;
    if (chk) begin
      x.sel16 = sel16; x.q = 4'(eq); x.tc = etc; x.wrap = ew;
      sb.push_back(x);
    end
  endtask

  initial begin
    // 1: reset then count up through the wrap
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++)
      step(1, 0, 1, 0, 0, 1, 1, k % 10, k == 9, k >= 10);
    // 2: load 3 then count down across zero
    step(1, 0, 1, 1, 3, 0, 0, 2, 0, 1);
    step(1, 0, 1, 0, 0, 1, 0, 3, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0, 9, 0, 1);
    step(1, 0, 1, 0, 0, 0, 0, 8, 0, 1);
    // 3: saturating load beats count enable; boundary value 10 also clamps
    step(1, 0, 1, 1, 13, 1, 1, 8, 0, 1);
    step(1, 0, 1, 1, 10, 0, 1, 9, 0, 0);
    step(1, 0, 1, 1, 5, 1, 0, 9, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 5, 0, 0);
    // 4: full-range counter rolls 15 -> 0 and holds
    step(0, 1, 1, 1, 15, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 1, 15, 1, 0);
    step(1, 1, 1, 0, 0, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0, 1, 0);
    step(1, 1, 1, 0, 0, 0, 0, 15, 0, 1);
    // 5: set wrap, reach 7, then reset overrides load and enable
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0, 9, 0, 1);
    step(1, 0, 1, 0, 0, 1, 0, 8, 0, 1);
    step(1, 0, 0, 1, 3, 1, 1, 7, 0, 1);
    step(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    // 6: direction flips every cycle around 4
    step(0, 0, 1, 1, 4, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 1, 4, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 5, 0, 0);
    step(1, 0, 1, 0, 0, 1, 1, 4, 0, 0);
    step(1, 0, 1, 0, 0, 1, 0, 5, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 4, 0, 0);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
